// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: ALU (A) and load (L) push ports plus the register-file write port.
interface wb_port_arbiter_if #(
  parameter int unsigned REGISTER_WIDTH = 5,
  parameter int unsigned DATA_WIDTH     = 32
);
  logic                      a_valid;
  logic                      a_ready;
  logic                      a_wr_en;
  logic [REGISTER_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0]     a_data;
  logic                      l_valid;
  logic                      l_ready;
  logic                      l_wr_en;
  logic [REGISTER_WIDTH-1:0] l_reg;
  logic [DATA_WIDTH-1:0]     l_data;
  logic                      reg_wr_en;
  logic [REGISTER_WIDTH-1:0] wr_reg;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      grant_l;
  logic                      busy;

  // Producer side: drives both push ports, observes the write port.
  modport master (
    output a_valid, a_wr_en, a_reg, a_data,
    output l_valid, l_wr_en, l_reg, l_data,
    input  a_ready, l_ready,
    input  reg_wr_en, wr_reg, wr_data, grant_l, busy
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_wr_en, a_reg, a_data,
    input  l_valid, l_wr_en, l_reg, l_data,
    output a_ready, l_ready,
    output reg_wr_en, wr_reg, wr_data, grant_l, busy
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: per-source FIFOs (index 0 = ALU, 1 = load) drained by a
// load-priority arbiter with a starvation guard onto a registered register-file write port.
module wb_port_arbiter #(
  parameter int unsigned REGISTER_WIDTH = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_port_arbiter_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [StW-1:0]  StOne   = StW'(1);
  localparam logic [StW-1:0]  StMax   = StW'(STARVE_LIMIT);

  typedef struct packed {
    logic                      wr_en;
    logic [REGISTER_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  entry_t                    mem_q [2][FIFO_DEPTH];
  logic [PtrW-1:0]           wptr_q [2];
  logic [PtrW-1:0]           wptr_d [2];
  logic [PtrW-1:0]           rptr_q [2];
  logic [PtrW-1:0]           rptr_d [2];
  logic [CntW-1:0]           cnt_q [2];
  logic [CntW-1:0]           cnt_d [2];
  logic [StW-1:0]            starve_q, starve_d;
  logic                      reg_wr_en_q, reg_wr_en_d;
  logic [REGISTER_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      grant_l_q, grant_l_d;

  entry_t     in_entry [2];
  entry_t     head;
  logic [1:0] in_valid, ready, push, pop, nonempty;

  // Gather the two push ports into indexable form.
  always_comb begin
    in_valid    = {bus.l_valid, bus.a_valid};
    in_entry[0] = '{wr_en: bus.a_wr_en, rd: bus.a_reg, data: bus.a_data};
    in_entry[1] = '{wr_en: bus.l_wr_en, rd: bus.l_reg, data: bus.l_data};
  end

  // Handshake and arbitration: loads win unless A has lost STARVE_LIMIT times in a row.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      nonempty[p] = cnt_q[p] != '0;
      ready[p]    = cnt_q[p] != CntFull;
      push[p]     = in_valid[p] & ready[p];
    end
    pop = '0;
    if (nonempty[0] && (!nonempty[1] || starve_q == StMax)) begin
      pop[0] = 1'b1;
    end else if (nonempty[1]) begin
      pop[1] = 1'b1;
    end
  end

  // FIFO pointer and occupancy next state; pointers wrap naturally since depth is a power of 2.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wptr_d[p] = push[p] ? wptr_q[p] + PtrOne : wptr_q[p];
      rptr_d[p] = pop[p] ? rptr_q[p] + PtrOne : rptr_q[p];
      cnt_d[p]  = cnt_q[p];
      if (push[p] && !pop[p]) begin
        cnt_d[p] = cnt_q[p] + CntOne;
      end else if (pop[p] && !push[p]) begin
        cnt_d[p] = cnt_q[p] - CntOne;
      end
    end
  end

  // Starvation count and write-port next state; index/data hold when nothing pops.
  always_comb begin
    starve_d    = '0;
    if (nonempty == 2'b11 && pop[1]) begin
      starve_d = (starve_q == StMax) ? StMax : starve_q + StOne;
    end
    head        = pop[1] ? mem_q[1][rptr_q[1]] : mem_q[0][rptr_q[0]];
    reg_wr_en_d = 1'b0;
    grant_l_d   = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (|pop) begin
      reg_wr_en_d = head.wr_en;
      grant_l_d   = pop[1];
      wr_reg_d    = head.rd;
      wr_data_d   = head.data;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty, so no reset.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) begin
        mem_q[p][wptr_q[p]] <= in_entry[p];
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int p = 0; p < 2; p++) begin
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
      starve_q    <= '0;
      reg_wr_en_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      grant_l_q   <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        wptr_q[p] <= wptr_d[p];
        rptr_q[p] <= rptr_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
      starve_q    <= starve_d;
      reg_wr_en_q <= reg_wr_en_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      grant_l_q   <= grant_l_d;
    end
  end

  assign bus.a_ready   = ready[0];
  assign bus.l_ready   = ready[1];
  assign bus.busy      = |nonempty;
  assign bus.reg_wr_en = reg_wr_en_q;
  assign bus.wr_reg    = wr_reg_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.grant_l   = grant_l_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed pushes with a hand-ordered write scoreboard.
module tb_wb_port_arbiter;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;

  wb_port_arbiter_if #(.REGISTER_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

  wb_port_arbiter #(
    .REGISTER_WIDTH(RW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (2),
    .STARVE_LIMIT  (3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
    logic          g;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every issued write must match the next expected write.
  always @(negedge clk) begin
    if (bus.reg_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_write: actual reg=%0d data=0x%0h required=none",
                 bus.wr_reg, bus.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_reg", 64'(bus.wr_reg), 64'(e.r));
        chk("sb_data", 64'(bus.wr_data), 64'(e.d));
        chk("sb_grant_l", 64'(bus.grant_l), 64'(e.g));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold an A entry until accepted; returns at the start of the cycle after acceptance.
  task automatic drive_a(input logic we, input logic [RW-1:0] r, input logic [DW-1:0] d);
    logic acc;
    int   n;
    bus.a_valid = 1'b1;
    bus.a_wr_en = we;
    bus.a_reg   = r;
    bus.a_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.a_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL a_push_timeout: actual=not accepted required=accepted reg=%0d", r);
    end
    bus.a_valid = 1'b0;
  endtask

  task automatic drive_l(input logic we, input logic [RW-1:0] r, input logic [DW-1:0] d);
    logic acc;
    int   n;
    bus.l_valid = 1'b1;
    bus.l_wr_en = we;
    bus.l_reg   = r;
    bus.l_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.l_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL l_push_timeout: actual=not accepted required=accepted reg=%0d", r);
    end
    bus.l_valid = 1'b0;
  endtask

  task automatic exp_w(input int r, input int d, input logic g);
    exp_q.push_back('{r: RW'(r), d: DW'(d), g: g});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.a_valid = 1'b0; bus.a_wr_en = 1'b0; bus.a_reg = '0; bus.a_data = '0;
    bus.l_valid = 1'b0; bus.l_wr_en = 1'b0; bus.l_reg = '0; bus.l_data = '0;
    rst_n = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_reg_wr_en", 64'(bus.reg_wr_en), 0);
    chk("rst_wr_reg", 64'(bus.wr_reg), 0);
    chk("rst_wr_data", 64'(bus.wr_data), 0);
    chk("rst_grant_l", 64'(bus.grant_l), 0);
    chk("rst_a_ready", 64'(bus.a_ready), 1);
    chk("rst_l_ready", 64'(bus.l_ready), 1);
    chk("rst_busy", 64'(bus.busy), 0);
    cyc(1);

    // Single ALU write: visible two cycles after the push cycle
    bus.a_valid = 1'b1; bus.a_wr_en = 1'b1; bus.a_reg = 5'd5; bus.a_data = 32'hDEAD;
    exp_w(5, 32'hDEAD, 1'b0);
    cyc(1);
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("single_c1_wr_en", 64'(bus.reg_wr_en), 0);
    chk("single_c1_busy", 64'(bus.busy), 1);
    @(negedge clk);
    chk("single_c2_wr_en", 64'(bus.reg_wr_en), 1);
    chk("single_c2_reg", 64'(bus.wr_reg), 5);
    chk("single_c2_grant_l", 64'(bus.grant_l), 0);
    @(negedge clk);
    chk("single_c3_wr_en", 64'(bus.reg_wr_en), 0);
    chk("single_c3_reg_hold", 64'(bus.wr_reg), 5);
    chk("single_c3_busy", 64'(bus.busy), 0);
    cyc(1);

    // Simultaneous push: load first, ALU next cycle
    bus.a_valid = 1'b1; bus.a_wr_en = 1'b1; bus.a_reg = 5'd1; bus.a_data = 32'h11;
    bus.l_valid = 1'b1; bus.l_wr_en = 1'b1; bus.l_reg = 5'd2; bus.l_data = 32'h22;
    exp_w(2, 32'h22, 1'b1);
    exp_w(1, 32'h11, 1'b0);
    cyc(1);
    bus.a_valid = 1'b0;
    bus.l_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("simul_c2_grant_l", 64'(bus.grant_l), 1);
    chk("simul_c2_reg", 64'(bus.wr_reg), 2);
    @(negedge clk);
    chk("simul_c3_wr_en", 64'(bus.reg_wr_en), 1);
    chk("simul_c3_grant_l", 64'(bus.grant_l), 0);
    chk("simul_c3_reg", 64'(bus.wr_reg), 1);
    cyc(3);

    // Starvation: three L wins, then the forced A write, then L resumes
    for (int i = 0; i < 3; i++) exp_w(10 + i, 32'h100 + i, 1'b1);
    exp_w(9, 32'h99, 1'b0);
    for (int i = 3; i < 6; i++) exp_w(10 + i, 32'h100 + i, 1'b1);
    fork
      drive_a(1'b1, 5'd9, 32'h99);
      begin
        for (int i = 0; i < 6; i++) drive_l(1'b1, RW'(10 + i), DW'(32'h100 + i));
      end
    join
    cyc(5);

    // Backpressure: A full after two, third accepted only after the first A pop
    for (int i = 0; i < 3; i++) exp_w(3 + i, 32'h200 + i, 1'b1);
    exp_w(20, 32'hA0, 1'b0);
    for (int i = 3; i < 6; i++) exp_w(3 + i, 32'h200 + i, 1'b1);
    exp_w(21, 32'hA1, 1'b0);
    for (int i = 6; i < 8; i++) exp_w(3 + i, 32'h200 + i, 1'b1);
    exp_w(22, 32'hA2, 1'b0);
    fork
      begin
        for (int i = 0; i < 3; i++) drive_a(1'b1, RW'(20 + i), DW'(32'hA0 + i));
      end
      begin
        for (int i = 0; i < 8; i++) drive_l(1'b1, RW'(3 + i), DW'(32'h200 + i));
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_c2_a_ready", 64'(bus.a_ready), 0);
        repeat (2) @(negedge clk);
        chk("bp_c4_a_ready", 64'(bus.a_ready), 0);
        @(negedge clk);
        chk("bp_c5_a_ready", 64'(bus.a_ready), 1);
      end
    join
    cyc(6);

    // wr_en=0 entry retires silently, in order ahead of the next A entry
    bus.a_valid = 1'b1; bus.a_wr_en = 1'b0; bus.a_reg = 5'd7; bus.a_data = 32'h77;
    cyc(1);
    bus.a_wr_en = 1'b1; bus.a_reg = 5'd8; bus.a_data = 32'h88;
    exp_w(8, 32'h88, 1'b0);
    @(negedge clk);
    chk("noen_c1_busy", 64'(bus.busy), 1);
    cyc(1);
    bus.a_valid = 1'b0;
    @(negedge clk);
    chk("noen_c2_wr_en", 64'(bus.reg_wr_en), 0);
    chk("noen_c2_grant_l", 64'(bus.grant_l), 0);
    @(negedge clk);
    chk("noen_c3_wr_en", 64'(bus.reg_wr_en), 1);
    chk("noen_c3_reg", 64'(bus.wr_reg), 8);
    cyc(3);

    // Reset mid-flight: only the load popped before reset escapes
    bus.a_valid = 1'b1; bus.a_wr_en = 1'b1; bus.a_reg = 5'd12; bus.a_data = 32'hC0;
    bus.l_valid = 1'b1; bus.l_wr_en = 1'b1; bus.l_reg = 5'd13; bus.l_data = 32'hD0;
    exp_w(13, 32'hD0, 1'b1);
    cyc(1);
    bus.a_reg = 5'd14; bus.a_data = 32'hC1;
    bus.l_reg = 5'd15; bus.l_data = 32'hD1;
    cyc(1);
    bus.a_valid = 1'b0;
    bus.l_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_pre_busy", 64'(bus.busy), 1);
    chk("mid_pre_grant_l", 64'(bus.grant_l), 1);
    cyc(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_busy", 64'(bus.busy), 0);
    chk("mid_post_a_ready", 64'(bus.a_ready), 1);
    chk("mid_post_l_ready", 64'(bus.l_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_post_no_write", 64'(bus.reg_wr_en), 0);
    end

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
